// File: rtl/mips_trace_pkg.sv
// Shared definitions for the MIPS trace buffer:
// FSM states, record layout and record pack/unpack helpers.
package mips_trace_pkg;

    localparam int REC_W    = 98;
    localparam int PC_HI    = 97;
    localparam int PC_LO    = 66;
    localparam int INSTR_HI = 65;
    localparam int INSTR_LO = 34;
    localparam int ALU_HI   = 33;
    localparam int ALU_LO   = 2;
    localparam int SEL_BIT  = 1;
    localparam int ZERO_BIT = 0;

    localparam logic [1:0] ST_IDLE_V    = 2'd0;
    localparam logic [1:0] ST_ARMED_V   = 2'd1;
    localparam logic [1:0] ST_CAPTURE_V = 2'd2;
    localparam logic [1:0] ST_DONE_V    = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = ST_IDLE_V,
        ST_ARMED   = ST_ARMED_V,
        ST_CAPTURE = ST_CAPTURE_V,
        ST_DONE    = ST_DONE_V
    } trace_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] alu;
        logic        sel_branchornot;
        logic        iszero;
    } trace_rec_t;

    function automatic logic [REC_W-1:0] pack_rec(input trace_rec_t r);
        logic [REC_W-1:0] v;
        v = '0;
        v[PC_HI:PC_LO]       = r.pc;
        v[INSTR_HI:INSTR_LO] = r.instr;
        v[ALU_HI:ALU_LO]     = r.alu;
        v[SEL_BIT]           = r.sel_branchornot;
        v[ZERO_BIT]          = r.iszero;
        return v;
    endfunction

    function automatic trace_rec_t unpack_rec(input logic [REC_W-1:0] v);
        trace_rec_t r;
        r.pc              = v[PC_HI:PC_LO];
        r.instr           = v[INSTR_HI:INSTR_LO];
        r.alu             = v[ALU_HI:ALU_LO];
        r.sel_branchornot = v[SEL_BIT];
        r.iszero          = v[ZERO_BIT];
        return r;
    endfunction

endpackage

// File: rtl/trace_fifo_mem.sv
// DEPTH x REC_W record storage: one write port, one registered read port.
// The array itself is not reset; only the read register is.
// A write to the address being read lands directly in the read register so a
// freshly written head record appears together with the count update.
module trace_fifo_mem
    import mips_trace_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [REC_W-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [REC_W-1:0] o_rdata
);

    logic [REC_W-1:0] r_mem [DEPTH];
    logic [REC_W-1:0] r_rdata;

    // Write port.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Registered read with write-through bypass.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdata <= '0;
        end else if (i_we && (i_waddr == i_raddr)) begin
            r_rdata <= i_wdata;
        end else begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mips_trace_buffer.sv
// Trace buffer for MIPS_CPU probe outputs: arm, trigger on a PC match, record
// a window of qualifying cycles into a first-word-fall-through FIFO.
// Build option MIPS_TRACE_BRANCH_FILTER_EN: only taken-branch cycles qualify
// after the trigger, and the window counts taken branches only.
//
// state      | meaning
// -----------+----------------------------------------------
// ST_IDLE    | no recording, FIFO may still drain
// ST_ARMED   | waiting for cap_pcout == trig_pc
// ST_CAPTURE | recording qualifying cycles until window full
// ST_DONE    | no recording, returns to IDLE once drained
module mips_trace_buffer
    import mips_trace_pkg::*;
#(
    parameter  int DEPTH   = 16,
    parameter  int CAP_LEN = 16,
    localparam int AW      = $clog2(DEPTH),
    localparam int CW      = AW + 1
) (
    input  logic             globalclock,
    input  logic             globalreset,
    input  logic             arm,
    input  logic [31:0]      trig_pc,
    input  logic [31:0]      cap_pcout,
    input  logic [31:0]      cap_instruction,
    input  logic [31:0]      cap_aluresult,
    input  logic             cap_sel_branchornot,
    input  logic             cap_iszero,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [REC_W-1:0] rd_data,
    output logic [1:0]       state,
    output logic [CW-1:0]    count,
    output logic             dropped
);

    trace_state_e     r_state;
    trace_state_e     w_state_nxt;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    w_rd_addr;
    logic [CW-1:0]    r_count;
    logic [15:0]      r_window;
    logic [15:0]      w_window_nxt;
    logic [16:0]      w_window_inc;
    logic             r_dropped;
    logic             w_full;
    logic             w_pop;
    logic             w_try;
    logic             w_push;
    logic             w_drop;
    logic             w_match;
    logic             w_qual;
    trace_rec_t       w_rec;
    logic [REC_W-1:0] w_rec_bits;

    assign w_match      = (cap_pcout == trig_pc);
    assign w_full       = (r_count == CW'(DEPTH));
    assign w_pop        = (r_count != '0) && rd_ready && !arm;
    assign w_window_inc = {1'b0, r_window} + 17'd1;

`ifdef MIPS_TRACE_BRANCH_FILTER_EN
    assign w_qual = cap_sel_branchornot;
`else
    assign w_qual = 1'b1;
`endif

    assign w_rec.pc              = cap_pcout;
    assign w_rec.instr           = cap_instruction;
    assign w_rec.alu             = cap_aluresult;
    assign w_rec.sel_branchornot = cap_sel_branchornot;
    assign w_rec.iszero          = cap_iszero;
    assign w_rec_bits            = pack_rec(w_rec);

    // Next-state, window and push/drop decisions; arm overrides everything.
    always_comb begin
        w_state_nxt  = r_state;
        w_window_nxt = r_window;
        w_try        = 1'b0;
        case (r_state)
            ST_IDLE: begin
            end
            ST_ARMED: begin
                if (w_match) begin
                    w_try = 1'b1;
`ifdef MIPS_TRACE_BRANCH_FILTER_EN
                    // Trigger is recorded but does not count toward the window.
                    w_window_nxt = 16'd0;
                    w_state_nxt  = ST_CAPTURE;
`else
                    w_window_nxt = 16'd1;
                    w_state_nxt  = (CAP_LEN == 1) ? ST_DONE : ST_CAPTURE;
`endif
                end
            end
            ST_CAPTURE: begin
                if (w_qual) begin
                    w_try        = 1'b1;
                    w_window_nxt = w_window_inc[15:0];
                    if (w_window_inc == 17'(CAP_LEN)) begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (r_count == '0) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        w_push = w_try && (!w_full || w_pop);
        w_drop = w_try && w_full && !w_pop;
        if (arm) begin
            w_state_nxt  = ST_ARMED;
            w_window_nxt = 16'd0;
            w_push       = 1'b0;
            w_drop       = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge globalclock or negedge globalreset) begin
        if (!globalreset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Pointers, occupancy, window counter and sticky drop flag.
    always_ff @(posedge globalclock or negedge globalreset) begin
        if (!globalreset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_window  <= '0;
            r_dropped <= 1'b0;
        end else if (arm) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_window  <= '0;
            r_dropped <= 1'b0;
        end else begin
            r_window <= w_window_nxt;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_dropped <= 1'b1;
            end
        end
    end

    // Read address looks one pop ahead so rd_data tracks the new head.
    assign w_rd_addr = arm ? '0 : (r_rd_ptr + AW'(w_pop));

    trace_fifo_mem #(
        .DEPTH(DEPTH)
    ) u_mem (
        .i_clk   (globalclock),
        .i_rst_n (globalreset),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_rec_bits),
        .i_raddr (w_rd_addr),
        .o_rdata (rd_data)
    );

    assign rd_valid = (r_count != '0);
    assign state    = r_state;
    assign count    = r_count;
    assign dropped  = r_dropped;

endmodule

// File: tb/tb_mips_trace_buffer.sv
// Directed bench for mips_trace_buffer with a per-instance scoreboard.
// Instance 0: DEPTH 16 / CAP_LEN 4, instance 1: DEPTH 4 / CAP_LEN 6,
// instance 2: DEPTH 16 / CAP_LEN 3 (branch-filter window when
// MIPS_TRACE_BRANCH_FILTER_EN is defined).
module tb_mips_trace_buffer;

`ifdef MIPS_TRACE_BRANCH_FILTER_EN
    localparam logic SEL_ALL = 1'b1;
    localparam int   EXTRA   = 1;
`else
    localparam logic SEL_ALL = 1'b0;
    localparam int   EXTRA   = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc, instr, alu;
    logic        sel, iz;
    logic        arm [3];
    logic        rdy [3];
    logic [31:0] trig [3];
    logic        vld [3];
    logic [97:0] dat [3];
    logic [1:0]  st [3];
    logic        drp [3];
    logic [4:0]  cnt0, cnt2;
    logic [2:0]  cnt1;

    logic [97:0] q [3][$];
    logic [97:0] pend [3];
    logic        pend_v [3];
    int          n_vec = 0;
    int          n_miss = 0;
    logic [31:0] p;
    int          n;
    logic        s;

    always #50 clk = ~clk;

    mips_trace_buffer #(.DEPTH(16), .CAP_LEN(4)) u_a (
        .globalclock(clk), .globalreset(rst_n), .arm(arm[0]), .trig_pc(trig[0]),
        .cap_pcout(pc), .cap_instruction(instr), .cap_aluresult(alu),
        .cap_sel_branchornot(sel), .cap_iszero(iz),
        .rd_valid(vld[0]), .rd_ready(rdy[0]), .rd_data(dat[0]),
        .state(st[0]), .count(cnt0), .dropped(drp[0]));

    mips_trace_buffer #(.DEPTH(4), .CAP_LEN(6)) u_b (
        .globalclock(clk), .globalreset(rst_n), .arm(arm[1]), .trig_pc(trig[1]),
        .cap_pcout(pc), .cap_instruction(instr), .cap_aluresult(alu),
        .cap_sel_branchornot(sel), .cap_iszero(iz),
        .rd_valid(vld[1]), .rd_ready(rdy[1]), .rd_data(dat[1]),
        .state(st[1]), .count(cnt1), .dropped(drp[1]));

    mips_trace_buffer #(.DEPTH(16), .CAP_LEN(3)) u_c (
        .globalclock(clk), .globalreset(rst_n), .arm(arm[2]), .trig_pc(trig[2]),
        .cap_pcout(pc), .cap_instruction(instr), .cap_aluresult(alu),
        .cap_sel_branchornot(sel), .cap_iszero(iz),
        .rd_valid(vld[2]), .rd_ready(rdy[2]), .rd_data(dat[2]),
        .state(st[2]), .count(cnt2), .dropped(drp[2]));

    task automatic chk(input string tag, input logic [97:0] obs, input logic [97:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic b);
        pc    = a;
        instr = a ^ 32'h8C01_0000;
        alu   = {a[15:0], a[31:16]} + 32'd7;
        sel   = b;
        iz    = a[2];
    endtask

    function automatic logic [97:0] exp_rec(input logic [31:0] a, input logic b);
        return {a, a ^ 32'h8C01_0000, {a[15:0], a[31:16]} + 32'd7, b, a[2]};
    endfunction

    task automatic exp_push(input int k, input logic [97:0] r);
        pend[k]   = r;
        pend_v[k] = 1'b1;
    endtask

    // One clock: check handshakes of the current cycle, advance, then commit
    // records that the DUT should now be holding.
    task automatic cyc();
        for (int k = 0; k < 3; k++) begin
            if (rdy[k]) begin
                chk($sformatf("rd_valid%0d", k), 98'(vld[k]), 98'(q[k].size() != 0));
                if (vld[k] && (q[k].size() != 0)) begin
                    logic [97:0] e;
                    e = q[k].pop_front();
                    chk($sformatf("rd_data%0d", k), dat[k], e);
                end
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            if (pend_v[k]) begin
                q[k].push_back(pend[k]);
                pend_v[k] = 1'b0;
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < 3; k++) begin
            arm[k]    = 1'b0;
            rdy[k]    = 1'b0;
            trig[k]   = 32'hFFFF_FFFF;
            pend_v[k] = 1'b0;
        end
        drive(32'h0040_0000, 1'b0);
        #20;
        // Reset state
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_state%0d", k), 98'(st[k]), 98'(0));
            chk($sformatf("rst_valid%0d", k), 98'(vld[k]), 98'(0));
            chk($sformatf("rst_data%0d", k), dat[k], 98'(0));
            chk($sformatf("rst_dropped%0d", k), 98'(drp[k]), 98'(0));
        end
        chk("rst_count0", 98'(cnt0), 98'(0));
        chk("rst_count1", 98'(cnt1), 98'(0));
        chk("rst_count2", 98'(cnt2), 98'(0));
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic window, no readout during capture
        trig[0] = 32'h0040_0008;
        arm[0] = 1'b1;
        drive(32'h0040_0000, SEL_ALL);
        cyc();
        arm[0] = 1'b0;
        q[0].delete();
        for (int i = 1; i <= 8; i++) begin
            p = 32'h0040_0000 + 32'(4 * i);
            drive(p, SEL_ALL);
            if (p >= 32'h0040_0008 && p <= 32'h0040_0014 + 32'(4 * EXTRA))
                exp_push(0, exp_rec(p, SEL_ALL));
            cyc();
        end
        chk("basic_state", 98'(st[0]), 98'(3));
        chk("basic_count", 98'(cnt0), 98'(4 + EXTRA));
        chk("basic_dropped", 98'(drp[0]), 98'(0));
        chk("basic_valid", 98'(vld[0]), 98'(1));
        rdy[0] = 1'b1;
        repeat (8) cyc();
        chk("basic_drained", 98'(q[0].size()), 98'(0));
        chk("basic_idle", 98'(st[0]), 98'(0));
        chk("basic_count_end", 98'(cnt0), 98'(0));

        // Simultaneous push and pop, ready held high
        trig[0] = 32'h0040_0108;
        arm[0] = 1'b1;
        drive(32'h0040_0100, SEL_ALL);
        cyc();
        arm[0] = 1'b0;
        q[0].delete();
        for (int i = 1; i <= 8; i++) begin
            p = 32'h0040_0100 + 32'(4 * i);
            drive(p, SEL_ALL);
            if (p >= 32'h0040_0108 && p <= 32'h0040_0114 + 32'(4 * EXTRA))
                exp_push(0, exp_rec(p, SEL_ALL));
            cyc();
            if (i >= 2 && i <= 5 + EXTRA)
                chk($sformatf("pp_count_i%0d", i), 98'(cnt0), 98'(1));
        end
        chk("pp_drained", 98'(q[0].size()), 98'(0));
        chk("pp_idle", 98'(st[0]), 98'(0));

        // Re-arm during capture with three records held
        rdy[0] = 1'b0;
        trig[0] = 32'h0040_0404;
        arm[0] = 1'b1;
        drive(32'h0040_0400, SEL_ALL);
        cyc();
        arm[0] = 1'b0;
        q[0].delete();
        for (int i = 1; i <= 3; i++) begin
            p = 32'h0040_0400 + 32'(4 * i);
            drive(p, SEL_ALL);
            cyc();
        end
        chk("rearm_pre_count", 98'(cnt0), 98'(3));
        chk("rearm_pre_state", 98'(st[0]), 98'(2));
        arm[0] = 1'b1;
        drive(32'h0040_0410, SEL_ALL);
        cyc();
        arm[0] = 1'b0;
        q[0].delete();
        chk("rearm_count", 98'(cnt0), 98'(0));
        chk("rearm_valid", 98'(vld[0]), 98'(0));
        chk("rearm_state", 98'(st[0]), 98'(1));
        chk("rearm_dropped", 98'(drp[0]), 98'(0));
        trig[0] = 32'hFFFF_FFFF;

        // Overflow on the 4-deep instance
        trig[1] = 32'h0040_0208;
        arm[1] = 1'b1;
        drive(32'h0040_0200, SEL_ALL);
        cyc();
        arm[1] = 1'b0;
        q[1].delete();
        for (int i = 1; i <= 10; i++) begin
            p = 32'h0040_0200 + 32'(4 * i);
            drive(p, SEL_ALL);
            if (p >= 32'h0040_0208 && p <= 32'h0040_0214)
                exp_push(1, exp_rec(p, SEL_ALL));
            cyc();
        end
        chk("ovf_count", 98'(cnt1), 98'(4));
        chk("ovf_dropped", 98'(drp[1]), 98'(1));
        chk("ovf_state", 98'(st[1]), 98'(3));
        rdy[1] = 1'b1;
        repeat (8) cyc();
        chk("ovf_drained", 98'(q[1].size()), 98'(0));
        chk("ovf_idle", 98'(st[1]), 98'(0));
        chk("ovf_sticky", 98'(drp[1]), 98'(1));
        rdy[1] = 1'b0;
        arm[1] = 1'b1;
        cyc();
        arm[1] = 1'b0;
        chk("ovf_rearm_dropped", 98'(drp[1]), 98'(0));
        chk("ovf_rearm_state", 98'(st[1]), 98'(1));
        trig[1] = 32'hFFFF_FFFF;

        // Window on instance 2: branches 2, 5 and 9 cycles after trigger
        trig[2] = 32'h0040_0508;
        arm[2] = 1'b1;
        drive(32'h0040_0500, 1'b0);
        cyc();
        arm[2] = 1'b0;
        q[2].delete();
        for (int i = 1; i <= 14; i++) begin
            n = i - 2;
            p = 32'h0040_0500 + 32'(4 * i);
            s = (n == 2) || (n == 5) || (n == 9);
            drive(p, s);
`ifdef MIPS_TRACE_BRANCH_FILTER_EN
            if (n == 0 || s) exp_push(2, exp_rec(p, s));
`else
            if (n >= 0 && n <= 2) exp_push(2, exp_rec(p, s));
`endif
            cyc();
        end
        chk("win_state", 98'(st[2]), 98'(3));
        chk("win_count", 98'(cnt2), 98'(3 + EXTRA));
        rdy[2] = 1'b1;
        repeat (8) cyc();
        chk("win_drained", 98'(q[2].size()), 98'(0));
        chk("win_idle", 98'(st[2]), 98'(0));
        rdy[2] = 1'b0;

        // Asynchronous reset 5.01 cycles after the trigger edge
        trig[0] = 32'h0040_0608;
        arm[0] = 1'b1;
        drive(32'h0040_0600, SEL_ALL);
        cyc();
        arm[0] = 1'b0;
        q[0].delete();
        for (int i = 1; i <= 2; i++) begin
            drive(32'h0040_0600 + 32'(4 * i), SEL_ALL);
            cyc();
        end
        chk("mid_pre_count", 98'(cnt0), 98'(1));
        for (int i = 3; i <= 6; i++) begin
            drive(32'h0040_0600 + 32'(4 * i), SEL_ALL);
            cyc();
        end
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_state", 98'(st[0]), 98'(0));
        chk("mid_rst_count", 98'(cnt0), 98'(0));
        chk("mid_rst_valid", 98'(vld[0]), 98'(0));
        chk("mid_rst_state1", 98'(st[1]), 98'(0));
        for (int k = 0; k < 3; k++) q[k].delete();
        #20 rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
